memory_layer_controller: RTL and testbench

Learning-phase control FSM for the GAM memory layer. It drives every enable, read/write strobe and mux/demux select of the memory-layer datapath, and consumes that datapath's comparator result. For each presented sample (x, c) it runs the full learning step: scan the stored nodes of class c, find the two nearest winners, threshold-test the first winner, then either insert a new node or update both winners and connect them.

---
 rtl/GAM_package.sv | 80 ++++++++
 rtl/memory_layer_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_memory_layer_controller.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/GAM_package.sv
// GAM_package: shared types, select codes and state encoding for the
// GAM memory-layer learning controller.
package GAM_package;

  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } comparator_T;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } RD_WR_T;

  localparam logic [1:0] MUX1_NODE_CNT = 2'd0;
  localparam logic [1:0] MUX1_SCAN_CNT = 2'd1;
  localparam logic [1:0] MUX1_S1       = 2'd2;
  localparam logic [1:0] MUX1_S2       = 2'd3;

  localparam logic [1:0] MUX2_X        = 2'd0;
  localparam logic [1:0] MUX2_WS1      = 2'd1;
  localparam logic [1:0] MUX2_WS2      = 2'd2;

  localparam logic [1:0] MUX3_TH_INIT  = 2'd0;
  localparam logic [1:0] MUX3_TH_S1    = 2'd2;

  localparam logic [1:0] MUX4_M_INIT   = 2'd0;
  localparam logic [1:0] MUX4_M_INC    = 2'd1;

  localparam logic [1:0] MUX5_CLASS    = 2'd0;
  localparam logic [1:0] MUX5_SCAN     = 2'd1;
  localparam logic [1:0] MUX5_THS1     = 2'd2;

  localparam logic [1:0] MUX6_CX       = 2'd0;
  localparam logic [1:0] MUX6_TOTAL    = 2'd1;
  localparam logic [1:0] MUX6_MIN1     = 2'd2;

  localparam logic [1:0] DEMUX_ED      = 2'd0;
  localparam logic [1:0] DEMUX_WS1     = 2'd1;
  localparam logic [1:0] DEMUX_WS2     = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SCAN_CHK,
    SCAN_RD,
    SCAN_CMP,
    THR_RD,
    THR_CMP,
    INSERT,
    UPD_S1,
    RD_S2,
    UPD_S2,
    CONNECT,
    FINISH
  } mlc_state_T;

  typedef struct packed {
    logic       ld_upcounter;
    logic       en_upcounter;
    logic       en_node_counter;
    logic       x_c;
    logic       c_c;
    logic       w_c;
    logic       t_c;
    logic       m_c;
    RD_WR_T     rd_wr;
    logic [1:0] mux1;
    logic [1:0] mux2;
    logic [1:0] mux3;
    logic [1:0] mux4;
    logic [1:0] mux5;
    logic [1:0] mux6;
    logic [1:0] demux;
    logic       busy;
    logic       done;
  } mlc_out_T;

endpackage

// File: rtl/memory_layer_controller.sv
// memory_layer_controller: learning-phase FSM driving the GAM memory-layer datapath.
// Define GAM_CTRL_CONNECT_EN to include the CONNECT state that links both winners.
module memory_layer_controller
  import GAM_package::*;
#(
  parameter int unsigned NODE_MAX = 64,
  parameter int unsigned CW       = $clog2(NODE_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        last_sample,
  input  comparator_T comparator_c,
  output logic        ld_upcounter,
  output logic        en_upcounter,
  output logic        en_node_counter,
  output logic        en_connection,
  output logic        en_2min,
  output logic        learning_done,
  output logic        X_c,
  output logic        C_c,
  output logic        W_c,
  output logic        T_c,
  output logic        M_c,
  output RD_WR_T      RD_WR_c,
  output logic [1:0]  mux1_sel,
  output logic [1:0]  mux2_sel,
  output logic [1:0]  mux3_sel,
  output logic [1:0]  mux4_sel,
  output logic [1:0]  mux5_sel,
  output logic [1:0]  mux6_sel,
  output logic [1:0]  demux_sel,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  mlc_state_T      state;
  mlc_state_T      state_nx;
  mlc_out_T        out_q;
  mlc_out_T        out_nx;
  logic [CW-1:0]   node_total;
  logic [1:0]      match_cnt;
  logic            last_q;
  logic            overflow_q;
  logic            learning_done_q;
  logic            node_full;

  assign node_full = (node_total == CW'(NODE_MAX));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start && !learning_done_q) state_nx = LOAD;
      LOAD:     state_nx = SCAN_CHK;
      SCAN_CHK: begin
        if (comparator_c == EQ) state_nx = (match_cnt == 2'd0) ? INSERT : THR_RD;
        else                    state_nx = SCAN_RD;
      end
      SCAN_RD:  state_nx = SCAN_CMP;
      SCAN_CMP: state_nx = SCAN_CHK;
      THR_RD:   state_nx = THR_CMP;
      THR_CMP:  state_nx = (comparator_c == LT) ? INSERT : UPD_S1;
      INSERT:   state_nx = FINISH;
      UPD_S1:   state_nx = (match_cnt == 2'd1) ? FINISH : RD_S2;
      RD_S2:    state_nx = UPD_S2;
`ifdef GAM_CTRL_CONNECT_EN
      UPD_S2:   state_nx = CONNECT;
`else
      UPD_S2:   state_nx = FINISH;
`endif
      CONNECT:  state_nx = FINISH;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and
  // line up with the state they belong to.
  always_comb begin
    out_nx       = '0;
    out_nx.rd_wr = RD;
    out_nx.busy  = (state_nx != IDLE);
    case (state_nx)
      LOAD: begin
        out_nx.ld_upcounter = 1'b1;
        out_nx.x_c          = 1'b1;
        out_nx.c_c          = 1'b1;
        out_nx.rd_wr        = WR;
      end
      SCAN_CHK: begin
        out_nx.mux5 = MUX5_SCAN;
        out_nx.mux6 = MUX6_TOTAL;
      end
      SCAN_RD: begin
        out_nx.mux1  = MUX1_SCAN_CNT;
        out_nx.c_c   = 1'b1;
        out_nx.w_c   = 1'b1;
        out_nx.demux = DEMUX_ED;
      end
      SCAN_CMP: begin
        out_nx.mux5         = MUX5_CLASS;
        out_nx.mux6         = MUX6_CX;
        out_nx.en_upcounter = 1'b1;
      end
      THR_RD: begin
        out_nx.mux1  = MUX1_S1;
        out_nx.w_c   = 1'b1;
        out_nx.t_c   = 1'b1;
        out_nx.m_c   = 1'b1;
        out_nx.demux = DEMUX_WS1;
      end
      THR_CMP: begin
        out_nx.mux5 = MUX5_THS1;
        out_nx.mux6 = MUX6_MIN1;
      end
      INSERT: begin
        if (!node_full) begin
          out_nx.mux1            = MUX1_NODE_CNT;
          out_nx.x_c             = 1'b1;
          out_nx.c_c             = 1'b1;
          out_nx.w_c             = 1'b1;
          out_nx.t_c             = 1'b1;
          out_nx.m_c             = 1'b1;
          out_nx.rd_wr           = WR;
          out_nx.mux2            = MUX2_X;
          out_nx.mux3            = MUX3_TH_INIT;
          out_nx.mux4            = MUX4_M_INIT;
          out_nx.en_node_counter = 1'b1;
        end
      end
      UPD_S1: begin
        out_nx.mux1  = MUX1_S1;
        out_nx.w_c   = 1'b1;
        out_nx.t_c   = 1'b1;
        out_nx.m_c   = 1'b1;
        out_nx.rd_wr = WR;
        out_nx.mux2  = MUX2_WS1;
        out_nx.mux3  = MUX3_TH_S1;
        out_nx.mux4  = MUX4_M_INC;
      end
      RD_S2: begin
        out_nx.mux1  = MUX1_S2;
        out_nx.w_c   = 1'b1;
        out_nx.demux = DEMUX_WS2;
      end
      UPD_S2: begin
        out_nx.mux1  = MUX1_S2;
        out_nx.w_c   = 1'b1;
        out_nx.rd_wr = WR;
        out_nx.mux2  = MUX2_WS2;
      end
      FINISH:  out_nx.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      out_q           <= '0;
      node_total      <= '0;
      match_cnt       <= '0;
      last_q          <= 1'b0;
      overflow_q      <= 1'b0;
      learning_done_q <= 1'b0;
    end else begin
      state <= state_nx;
      out_q <= out_nx;
      if (state == IDLE && state_nx == LOAD) begin
        last_q    <= last_sample;
        match_cnt <= '0;
      end
      if (state == SCAN_CMP && comparator_c == EQ && match_cnt != 2'd2)
        match_cnt <= match_cnt + 2'd1;
      if (state_nx == INSERT) begin
        if (node_full) overflow_q <= 1'b1;
        else           node_total <= node_total + 1'b1;
      end
      if (state_nx == FINISH && last_q)
        learning_done_q <= 1'b1;
    end
  end

`ifdef GAM_CTRL_CONNECT_EN
  logic en_connection_q;

  always_ff @(posedge clk) begin
    if (rst) en_connection_q <= 1'b0;
    else     en_connection_q <= (state_nx == CONNECT);
  end

  assign en_connection = en_connection_q;
`else
  assign en_connection = 1'b0;
`endif

  // The 2-min unit must capture the ED in the very cycle the class compare
  // hits, so this enable follows the comparator rather than a register.
  assign en_2min = (state == SCAN_CMP) && (comparator_c == EQ);

  assign ld_upcounter    = out_q.ld_upcounter;
  assign en_upcounter    = out_q.en_upcounter;
  assign en_node_counter = out_q.en_node_counter;
  assign X_c             = out_q.x_c;
  assign C_c             = out_q.c_c;
  assign W_c             = out_q.w_c;
  assign T_c             = out_q.t_c;
  assign M_c             = out_q.m_c;
  assign RD_WR_c         = out_q.rd_wr;
  assign mux1_sel        = out_q.mux1;
  assign mux2_sel        = out_q.mux2;
  assign mux3_sel        = out_q.mux3;
  assign mux4_sel        = out_q.mux4;
  assign mux5_sel        = out_q.mux5;
  assign mux6_sel        = out_q.mux6;
  assign demux_sel       = out_q.demux;
  assign busy            = out_q.busy;
  assign done            = out_q.done;
  assign overflow        = overflow_q;
  assign learning_done   = learning_done_q;

endmodule

// File: tb/tb_memory_layer_controller.sv
// tb_memory_layer_controller: drives the controller through a small datapath
// model and predicts each learning step from the stored-class list.
module tb_memory_layer_controller;
  import GAM_package::*;

  localparam int NMAX = 6;
`ifdef GAM_CTRL_CONNECT_EN
  localparam int CONN = 1;
`else
  localparam int CONN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        last_sample = 1'b0;
  comparator_T comparator_c;
  logic        ld_upcounter, en_upcounter, en_node_counter, en_connection, en_2min;
  logic        learning_done, X_c, C_c, W_c, T_c, M_c;
  RD_WR_T      RD_WR_c;
  logic [1:0]  mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel;
  logic        busy, done, overflow;

  memory_layer_controller #(.NODE_MAX(NMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .last_sample(last_sample),
    .comparator_c(comparator_c),
    .ld_upcounter(ld_upcounter), .en_upcounter(en_upcounter),
    .en_node_counter(en_node_counter), .en_connection(en_connection),
    .en_2min(en_2min), .learning_done(learning_done),
    .X_c(X_c), .C_c(C_c), .W_c(W_c), .T_c(T_c), .M_c(M_c), .RD_WR_c(RD_WR_c),
    .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .mux3_sel(mux3_sel),
    .mux4_sel(mux4_sel), .mux5_sel(mux5_sel), .mux6_sel(mux6_sel),
    .demux_sel(demux_sel), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: scan counter, node counter, class memory, comparator.
  int          mem_cls [NMAX+1];
  int          dp_nodes = 0;
  int          scan_cnt = 0;
  int          rd_cls = 0;
  int          cx = 0;
  comparator_T thr_res = GT;

  function automatic comparator_T cmp(input int a, input int b);
    if (a < b) return LT;
    if (a == b) return EQ;
    return GT;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dp_nodes <= 0;
      scan_cnt <= 0;
    end else begin
      if (ld_upcounter) scan_cnt <= 0;
      else if (en_upcounter) scan_cnt <= scan_cnt + 1;
      if (C_c && RD_WR_c == RD && mux1_sel == MUX1_SCAN_CNT) rd_cls <= mem_cls[scan_cnt];
      if (en_node_counter && C_c && RD_WR_c == WR && mux1_sel == MUX1_NODE_CNT)
        mem_cls[dp_nodes] <= cx;
      if (en_node_counter) dp_nodes <= dp_nodes + 1;
    end
  end

  always_comb begin
    comparator_c = GT;
    if (mux5_sel == MUX5_SCAN && mux6_sel == MUX6_TOTAL)      comparator_c = cmp(scan_cnt, dp_nodes);
    else if (mux5_sel == MUX5_THS1 && mux6_sel == MUX6_MIN1)  comparator_c = thr_res;
    else if (mux5_sel == MUX5_CLASS && mux6_sel == MUX6_CX)   comparator_c = cmp(rd_cls, cx);
  end

  // Reference: list of stored classes plus sticky flags.
  int ref_cls[$];
  bit ref_ovf = 1'b0;
  bit ref_ld  = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [28:0] all_outs();
    return {ld_upcounter, en_upcounter, en_node_counter, en_connection, en_2min,
            learning_done, X_c, C_c, W_c, T_c, M_c, RD_WR_c, mux1_sel, mux2_sel,
            mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel, busy, done, overflow};
  endfunction

  function automatic int count_cls(input int c);
    int m = 0;
    foreach (ref_cls[i]) if (ref_cls[i] == c) m++;
    return m;
  endfunction

  function automatic int model_lat(input int c, input comparator_T thr);
    int n = ref_cls.size();
    int m = count_cls(c);
    if (m == 0) return 3*n + 4;
    if (thr == LT || m == 1) return 3*n + 6;
    return 3*n + 8 + CONN;
  endfunction

  task automatic clear_model();
    ref_cls.delete();
    ref_ovf = 1'b0;
    ref_ld  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    check("reset_outputs", int'(all_outs()), 0);
  endtask

  task automatic run_sample(input int c, input bit last, input comparator_T thr, input int exp_lat);
    int n, m, k, done_k, node_inc, wr, conn, min2, up, busy_low, bad_ins;
    int upd1_k, rds2_k, upd2_k, conn_k, ld_at_done;
    bit ins, full;
    int exp_inc, exp_wr, exp_conn;
    n = ref_cls.size();
    m = count_cls(c);
    full = (n >= NMAX);
    ins = (m == 0) || (thr == LT);
    exp_inc = (ins && !full) ? 1 : 0;
    exp_wr = ins ? exp_inc : ((m == 1) ? 1 : 2);
    exp_conn = (!ins && m >= 2) ? CONN : 0;
    k = 0; done_k = 0; node_inc = 0; wr = 0; conn = 0; min2 = 0; up = 0;
    busy_low = 0; bad_ins = 0; upd1_k = 0; rds2_k = 0; upd2_k = 0; conn_k = 0; ld_at_done = 0;

    @(negedge clk);
    cx = c; last_sample = last; thr_res = thr; start = 1'b1;
    while (done_k == 0 && k < exp_lat + 20) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (!busy) busy_low++;
      if (en_node_counter) begin
        node_inc++;
        if (!(X_c && C_c && W_c && T_c && M_c && RD_WR_c == WR && mux1_sel == 2'd0 &&
              mux2_sel == 2'd0 && mux3_sel == 2'd0 && mux4_sel == 2'd0)) bad_ins++;
      end
      if (RD_WR_c == WR && (W_c || T_c || M_c)) wr++;
      if (en_connection) begin conn++; conn_k = k; end
      if (en_2min) min2++;
      if (en_upcounter) up++;
      if (W_c && RD_WR_c == WR && mux1_sel == 2'd2) upd1_k = k;
      if (W_c && RD_WR_c == RD && mux1_sel == 2'd3) rds2_k = k;
      if (W_c && RD_WR_c == WR && mux1_sel == 2'd3) upd2_k = k;
      if (done) begin done_k = k; ld_at_done = int'(learning_done); end
    end

    if (ins) begin
      if (!full) ref_cls.push_back(c);
      else       ref_ovf = 1'b1;
    end
    if (last) ref_ld = 1'b1;

    check("done_latency", done_k, exp_lat);
    check("node_counter_pulses", node_inc, exp_inc);
    check("insert_strobes", bad_ins, 0);
    check("memory_writes", wr, exp_wr);
    check("connection_pulses", conn, exp_conn);
    check("en_2min_pulses", min2, m);
    check("scan_steps", up, n);
    check("busy_gap", busy_low, 0);
    check("learning_done_at_done", ld_at_done, int'(ref_ld));
    if (!ins && m >= 2) begin
      check("upd_s1_cycle", upd1_k, 3*n + 5);
      check("rd_s2_cycle", rds2_k, 3*n + 6);
      check("upd_s2_cycle", upd2_k, 3*n + 7);
      if (CONN == 1) check("connect_cycle", conn_k, 3*n + 8);
    end
    @(negedge clk);
    check("busy_after_finish", int'(busy), 0);
    check("done_single_cycle", int'(done), 0);
    check("overflow_flag", int'(overflow), int'(ref_ovf));
  endtask

  typedef struct {
    bit          do_rst;
    int          c;
    bit          last;
    comparator_T thr;
    int          lat;
    int          nodes;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 3, 1'b0, GT, 4, 1};
    tbl[1]  = '{1'b0, 1, 1'b0, GT, 7, 2};
    tbl[2]  = '{1'b0, 2, 1'b0, GT, 10, 3};
    tbl[3]  = '{1'b0, 4, 1'b0, GT, 13, 4};
    tbl[4]  = '{1'b0, 3, 1'b0, LT, 18, 5};
    tbl[5]  = '{1'b1, 3, 1'b0, GT, 4, 1};
    tbl[6]  = '{1'b0, 3, 1'b0, LT, 9, 2};
    tbl[7]  = '{1'b0, 1, 1'b0, GT, 10, 3};
    tbl[8]  = '{1'b0, 2, 1'b0, GT, 13, 4};
    tbl[9]  = '{1'b0, 3, 1'b0, GT, 20 + CONN, 4};
    tbl[10] = '{1'b0, 1, 1'b0, EQ, 18, 4};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_rst) do_reset();
      run_sample(tbl[i].c, tbl[i].last, tbl[i].thr, tbl[i].lat);
      check("node_total", dp_nodes, tbl[i].nodes);
    end

    // Fill to capacity, then a new class must overflow without writing.
    do_reset();
    for (int i = 0; i < NMAX; i++) run_sample(10 + i, 1'b0, GT, model_lat(10 + i, GT));
    run_sample(20, 1'b0, GT, 3*NMAX + 4);
    check("overflow_set", int'(overflow), 1);
    check("nodes_at_capacity", dp_nodes, NMAX);

    // Reset in the middle of a scan, then a clean step.
    begin
      bit found = 1'b0;
      do_reset();
      run_sample(1, 1'b0, GT, 4);
      run_sample(2, 1'b0, GT, 7);
      @(negedge clk);
      cx = 7; start = 1'b1;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (en_upcounter) found = 1'b1;
      end
      check("scan_cmp_reached", int'(found), 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_outputs", int'(all_outs()), 0);
      check("abort_busy", int'(busy), 0);
      rst = 1'b0;
      clear_model();
      run_sample(5, 1'b0, GT, 4);
      check("node_total_after_abort", dp_nodes, 1);
    end

    // Randomized steps against the class-list model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int s = 0; s < 14; s++) begin
        int c;
        comparator_T thr;
        c = int'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0:       thr = LT;
          1:       thr = EQ;
          default: thr = GT;
        endcase
        run_sample(c, 1'b0, thr, model_lat(c, thr));
      end
    end

    // Final sample: learning_done rises with done and blocks later starts.
    begin
      int busy_seen = 0;
      do_reset();
      run_sample(9, 1'b1, GT, 4);
      check("learning_done_sticky", int'(learning_done), 1);
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (busy) busy_seen++;
      end
      check("start_ignored_after_done", busy_seen, 0);
      check("learning_done_held", int'(learning_done), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
